// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding and address-field width helpers for the set-associative dcache
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_e;

    function automatic int off_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int line_bits, input int num_sets);
        return addr_bits - off_bits(line_bits) - idx_bits(num_sets);
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// rtl/dcache_way_array.sv - one cache way: valid/dirty flags plus tag and line storage
module dcache_way_array #(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256,
    parameter int WORD_BITS = 32,
    parameter int TAG_BITS  = 23
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(NUM_SETS)-1:0]           idx,
    output logic                                  rd_valid,
    output logic                                  rd_dirty,
    output logic [TAG_BITS-1:0]                   rd_tag,
    output logic [LINE_BITS-1:0]                  rd_line,
    input  logic                                  fill_en,
    input  logic [TAG_BITS-1:0]                   fill_tag,
    input  logic [LINE_BITS-1:0]                  fill_line,
    input  logic                                  store_en,
    input  logic [$clog2(LINE_BITS/WORD_BITS)-1:0] store_sel,
    input  logic [WORD_BITS-1:0]                  store_word
);

    logic [NUM_SETS-1:0]  valid;
    logic [NUM_SETS-1:0]  dirty;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0] data_mem [NUM_SETS];

    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (store_en) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx]  <= fill_tag;
            data_mem[idx] <= fill_line;
        end else if (store_en) begin
            data_mem[idx][store_sel*WORD_BITS +: WORD_BITS] <= store_word;
        end
    end

endmodule

// File: rtl/dcache_sa_ctrl.sv
// rtl/dcache_sa_ctrl.sv - N-way set-associative write-back write-allocate L1 data cache controller
module dcache_sa_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 2,
    parameter int LINE_BITS = 256,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WORD_BITS-1:0] p1_data_i,
    input  logic [ADDR_BITS-1:0] p1_addr_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [WORD_BITS-1:0] p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);

    localparam int OFF = off_bits(LINE_BITS);
    localparam int IDX = idx_bits(NUM_SETS);
    localparam int TAG = tag_bits(ADDR_BITS, LINE_BITS, NUM_SETS);
    localparam int SEL = OFF - 2;
    localparam int PTR = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic [SEL-1:0] sel;
    logic           req;
    logic           is_store;

    assign idx      = p1_addr_i[OFF+IDX-1:OFF];
    assign tag      = p1_addr_i[ADDR_BITS-1:OFF+IDX];
    assign sel      = p1_addr_i[OFF-1:2];
    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_store = p1_MemWrite_i;

    state_e               state, state_next;
    logic [LINE_BITS-1:0] fill_buf;
    logic [PTR-1:0]       rr_ptr [NUM_SETS];
    logic [PTR-1:0]       ptr_next;

    logic [NUM_WAYS-1:0]  way_valid, way_dirty, hit_vec, store_en, fill_en;
    logic [TAG-1:0]       way_tag  [NUM_WAYS];
    logic [LINE_BITS-1:0] way_line [NUM_WAYS];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        dcache_way_array #(
            .NUM_SETS (NUM_SETS),
            .LINE_BITS(LINE_BITS),
            .WORD_BITS(WORD_BITS),
            .TAG_BITS (TAG)
        ) u_way (
            .clk       (clk_i),
            .rst       (rst_i),
            .idx       (idx),
            .rd_valid  (way_valid[w]),
            .rd_dirty  (way_dirty[w]),
            .rd_tag    (way_tag[w]),
            .rd_line   (way_line[w]),
            .fill_en   (fill_en[w]),
            .fill_tag  (tag),
            .fill_line (fill_buf),
            .store_en  (store_en[w]),
            .store_sel (sel),
            .store_word(p1_data_i)
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == tag);
    end

    logic                 hit;
    logic [LINE_BITS-1:0] hit_line;
    logic [PTR-1:0]       victim;
    logic                 victim_found;
    logic                 victim_dirty;
    logic [TAG-1:0]       victim_tag;
    logic [LINE_BITS-1:0] victim_line;

    // Lowest invalid way wins; with every way valid the set's round-robin pointer picks.
    always_comb begin
        hit          = 1'b0;
        hit_line     = '0;
        victim       = rr_ptr[idx];
        victim_found = 1'b0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        victim_line  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (hit_vec[w]) begin
                hit      = 1'b1;
                hit_line = way_line[w];
            end
            if (!victim_found && !way_valid[w]) begin
                victim       = PTR'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (PTR'(w) == victim) begin
                victim_dirty = way_dirty[w];
                victim_tag   = way_tag[w];
                victim_line  = way_line[w];
            end
        end
    end

    assign ptr_next = (rr_ptr[idx] == PTR'(NUM_WAYS - 1)) ? '0 : rr_ptr[idx] + 1'b1;

    logic                 stall;
    logic                 store_hit;
    logic [WORD_BITS-1:0] load_data;

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        store_hit    = 1'b0;
        load_data    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        fill_en      = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        store_hit = is_store;
                        if (!is_store)
                            load_data = hit_line[sel*WORD_BITS +: WORD_BITS];
                    end else begin
                        stall      = 1'b1;
                        state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall        = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag, idx, {OFF{1'b0}}};
                mem_data_o   = victim_line;
                if (mem_ack_i)
                    state_next = ALLOCATE;
            end
            ALLOCATE: begin
                stall        = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFF{1'b0}}};
                if (mem_ack_i)
                    state_next = FILL;
            end
            FILL: begin
                stall      = 1'b1;
                state_next = IDLE;
                for (int w = 0; w < NUM_WAYS; w++)
                    fill_en[w] = (PTR'(w) == victim);
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces the CPU side quiet even while a request is held on the inputs.
    assign p1_stall_o = stall & ~rst_i;
    assign p1_data_o  = rst_i ? '0 : load_data;
    assign store_en   = hit_vec & {NUM_WAYS{store_hit & ~rst_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            for (int s = 0; s < NUM_SETS; s++)
                rr_ptr[s] <= '0;
        end else begin
            state <= state_next;
            if (state == FILL)
                rr_ptr[idx] <= ptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem_ack_i)
            fill_buf <= mem_data_i;
    end

`ifndef SYNTHESIS
    logic [ADDR_BITS-1:0] prev_addr;
    logic                 prev_stalled;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_addr    <= '0;
            prev_stalled <= 1'b0;
        end else begin
            prev_addr    <= p1_addr_i;
            prev_stalled <= p1_stall_o & req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(p1_MemRead_i && p1_MemWrite_i));
            assert (!(prev_stalled && req && (p1_addr_i != prev_addr)));
        end
    end
`endif

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// tb/tb_dcache_sa_ctrl.sv - directed self-checking bench for dcache_sa_ctrl (2-way default and 1-way/8-set variants)
module tb_dcache_sa_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel_b;
    logic         rd, wr, ack;
    logic [31:0]  addr, wdata;
    logic [255:0] mem_line;

    logic         rd_a, wr_a, ack_a, rd_b, wr_b, ack_b;
    logic [31:0]  data_a, data_b, maddr_a, maddr_b;
    logic         stall_a, stall_b, men_a, men_b, mwr_a, mwr_b;
    logic [255:0] mdata_a, mdata_b;

    logic [31:0]  o_data, o_maddr;
    logic         o_stall, o_men, o_mwr;
    logic [255:0] o_mdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rd_a  = rd & ~sel_b;
    assign wr_a  = wr & ~sel_b;
    assign ack_a = ack & ~sel_b;
    assign rd_b  = rd & sel_b;
    assign wr_b  = wr & sel_b;
    assign ack_b = ack & sel_b;

    assign o_data  = sel_b ? data_b  : data_a;
    assign o_stall = sel_b ? stall_b : stall_a;
    assign o_maddr = sel_b ? maddr_b : maddr_a;
    assign o_men   = sel_b ? men_b   : men_a;
    assign o_mwr   = sel_b ? mwr_b   : mwr_a;
    assign o_mdata = sel_b ? mdata_b : mdata_a;

    dcache_sa_ctrl u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_data_i    (wdata),
        .p1_addr_i    (addr),
        .p1_MemRead_i (rd_a),
        .p1_MemWrite_i(wr_a),
        .p1_data_o    (data_a),
        .p1_stall_o   (stall_a),
        .mem_data_i   (mem_line),
        .mem_ack_i    (ack_a),
        .mem_data_o   (mdata_a),
        .mem_addr_o   (maddr_a),
        .mem_enable_o (men_a),
        .mem_write_o  (mwr_a)
    );

    dcache_sa_ctrl #(.NUM_SETS(8), .NUM_WAYS(1)) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_data_i    (wdata),
        .p1_addr_i    (addr),
        .p1_MemRead_i (rd_b),
        .p1_MemWrite_i(wr_b),
        .p1_data_o    (data_b),
        .p1_stall_o   (stall_b),
        .mem_data_i   (mem_line),
        .mem_ack_i    (ack_b),
        .mem_data_o   (mdata_b),
        .mem_addr_o   (maddr_b),
        .mem_enable_o (men_b),
        .mem_write_o  (mwr_b)
    );

    function automatic logic [255:0] mk_line(input logic [31:0] seed);
        logic [255:0] l;
        for (int k = 0; k < 8; k++)
            l[k*32 +: 32] = seed + 32'(k);
        return l;
    endfunction

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hit_load(input string tg, input logic [31:0] a, input logic [31:0] exp);
        step();
        rd = 1'b1; wr = 1'b0; addr = a;
        #1;
        chk({tg, "_stall"}, 32'(o_stall), 32'd0);
        chk({tg, "_data"}, o_data, exp);
        chk({tg, "_men"}, 32'(o_men), 32'd0);
    endtask

    task automatic store_hit(input string tg, input logic [31:0] a, input logic [31:0] d);
        step();
        rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
        #1;
        chk({tg, "_stall"}, 32'(o_stall), 32'd0);
        chk({tg, "_data0"}, o_data, 32'd0);
        chk({tg, "_men"}, 32'(o_men), 32'd0);
    endtask

    task automatic access_miss(input string tg, input logic [31:0] a, input bit wb,
                               input logic [31:0] wb_addr, input logic [31:0] wb_w0,
                               input logic [31:0] wb_w1, input logic [31:0] seed,
                               input logic [31:0] exp);
        step();
        rd = 1'b1; wr = 1'b0; addr = a;
        #1;
        chk({tg, "_miss_stall"}, 32'(o_stall), 32'd1);
        chk({tg, "_miss_men"}, 32'(o_men), 32'd0);
        step();
        if (wb) begin
            chk({tg, "_wb_men"}, 32'(o_men), 32'd1);
            chk({tg, "_wb_wr"}, 32'(o_mwr), 32'd1);
            chk({tg, "_wb_addr"}, o_maddr, wb_addr);
            chk({tg, "_wb_w0"}, o_mdata[31:0], wb_w0);
            chk({tg, "_wb_w1"}, o_mdata[63:32], wb_w1);
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk({tg, "_rf_men"}, 32'(o_men), 32'd1);
        chk({tg, "_rf_wr"}, 32'(o_mwr), 32'd0);
        chk({tg, "_rf_addr"}, o_maddr, a & 32'hFFFF_FFE0);
        chk({tg, "_rf_stall"}, 32'(o_stall), 32'd1);
        mem_line = mk_line(seed);
        ack = 1'b1;
        step();
        ack = 1'b0;
        mem_line = '0;
        chk({tg, "_fill_men"}, 32'(o_men), 32'd0);
        chk({tg, "_fill_stall"}, 32'(o_stall), 32'd1);
        step();
        chk({tg, "_done_stall"}, 32'(o_stall), 32'd0);
        chk({tg, "_done_data"}, o_data, exp);
    endtask

    initial begin
        rst = 1'b1; sel_b = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
        addr = '0; wdata = '0; mem_line = '0;
        #2;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_men", 32'(o_men), 32'd0);
        chk("rst_mwr", 32'(o_mwr), 32'd0);
        chk("rst_maddr", o_maddr, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_mdata", o_mdata[31:0], 32'd0);
        step();
        rst = 1'b0;

        access_miss("t1", 32'h404, 1'b0, 0, 0, 0, 32'h1111_1110, 32'h1111_1111);
        hit_load("t2", 32'h404, 32'h1111_1111);

        access_miss("t3a", 32'h000, 1'b0, 0, 0, 0, 32'hA000_0000, 32'hA000_0000);
        access_miss("t3b", 32'h200, 1'b0, 0, 0, 0, 32'hB000_0000, 32'hB000_0000);
        store_hit("t3_st", 32'h004, 32'hDEAD_BEEF);
        hit_load("t3_ld", 32'h004, 32'hDEAD_BEEF);
        access_miss("t3c", 32'h400, 1'b1, 32'h000, 32'hA000_0000, 32'hDEAD_BEEF,
                    32'h1111_1110, 32'h1111_1110);

        hit_load("t4_hit", 32'h200, 32'hB000_0000);
        access_miss("t4", 32'h600, 1'b0, 0, 0, 0, 32'hC000_0000, 32'hC000_0000);
        hit_load("t4_keep", 32'h404, 32'h1111_1111);

        store_hit("t5_st", 32'h404, 32'h1234_5678);
        step();
        rd = 1'b1; wr = 1'b0; addr = 32'h200;
        #1;
        chk("t5_miss_stall", 32'(o_stall), 32'd1);
        step();
        chk("t5_wb_men", 32'(o_men), 32'd1);
        chk("t5_wb_addr", o_maddr, 32'h400);
        chk("t5_wb_w1", o_mdata[63:32], 32'h1234_5678);
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_men", 32'(o_men), 32'd0);
        chk("t5_rst_stall", 32'(o_stall), 32'd0);
        chk("t5_rst_mwr", 32'(o_mwr), 32'd0);
        ack = 1'b1;
        step();
        rst = 1'b0; ack = 1'b0; rd = 1'b0;
        access_miss("t5_after", 32'h600, 1'b0, 0, 0, 0, 32'hE000_0000, 32'hE000_0000);

        step();
        rd = 1'b0; wr = 1'b0; sel_b = 1'b1;
        access_miss("t6a", 32'h000, 1'b0, 0, 0, 0, 32'h3000_0000, 32'h3000_0000);
        store_hit("t6_st", 32'h000, 32'h55AA_55AA);
        access_miss("t6b", 32'h100, 1'b1, 32'h000, 32'h55AA_55AA, 32'h3000_0001,
                    32'h4000_0000, 32'h4000_0000);
        access_miss("t6c", 32'h000, 1'b0, 0, 0, 0, 32'h5000_0000, 32'h5000_0000);
        access_miss("t6d", 32'h100, 1'b0, 0, 0, 0, 32'h6000_0000, 32'h6000_0000);

        step();
        rd = 1'b0; wr = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
